// File: rtl/inst_encoder_loader_if.sv
// Field-bundle input stream and instruction-word output stream of inst_encoder_loader.
// The encoder (slave) consumes fields and produces addressed words; the host side is the master.
interface inst_encoder_loader_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_type;
    logic [6:0]               in_opcode;
    logic [4:0]               in_rd;
    logic [4:0]               in_rs1;
    logic [4:0]               in_rs2;
    logic [2:0]               in_funct3;
    logic [6:0]               in_funct7;
    logic [31:0]              in_imm;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_inst;
    logic [ADDR_W-1:0]        out_addr;
    logic [$clog2(DEPTH):0]   count;
    logic                     err_illegal;

    modport master (
        output in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, count, err_illegal
    );

    modport slave (
        input  in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, count, err_illegal
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs RV32 instruction fields into 32-bit words, queues them in a small FIFO and
// drains them with an incrementing word address for loading instruction memory.
module inst_encoder_loader #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  flush,
    inst_encoder_loader_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        TYPE_R  = 3'd0,
        TYPE_I  = 3'd1,
        TYPE_S  = 3'd2,
        TYPE_SB = 3'd3,
        TYPE_UJ = 3'd4,
        TYPE_U  = 3'd5
    } inst_type_e;

    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [31:0]       enc;
    logic              illegal;
    logic [31:0]       imm;
    logic              accept;
    logic              drain;

    assign imm = bus.in_imm;

    always_comb begin
        enc     = NOP;
        illegal = 1'b0;
        case (inst_type_e'(bus.in_type))
            TYPE_R:  enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
            TYPE_I:  enc = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            TYPE_S:  enc = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:0], bus.in_opcode};
            TYPE_SB: enc = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:1], imm[11], bus.in_opcode};
            TYPE_UJ: enc = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            TYPE_U:  enc = {imm[31:12], bus.in_rd, bus.in_opcode};
            default: begin
                enc     = NOP;
                illegal = 1'b1;
            end
        endcase
    end

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = bus.out_valid & bus.out_ready;

    // No bypass: a full FIFO refuses input even when the head is draining this edge.
    assign bus.in_ready    = (count_q != CNT_W'(DEPTH));
    assign bus.out_valid   = (count_q != '0);
    assign bus.out_inst    = mem[rd_ptr];
    assign bus.out_addr    = addr_q;
    assign bus.count       = count_q;
    assign bus.err_illegal = err_q;

    always_ff @(posedge clk) begin
        if (accept && !rst && !flush) begin
            mem[wr_ptr] <= enc;
        end
    end

    // An illegal accept coinciding with a flush is still reported, though the word is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept & illegal;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
                addr_q  <= BASE_ADDR;
            end else begin
                if (accept) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (drain) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    addr_q <= addr_q + ADDR_W'(4);
                end
                case ({accept, drain})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench for inst_encoder_loader: expected words queued on accept, checked on drain.
module tb_inst_encoder_loader;
    localparam int                DEPTH     = 4;
    localparam int                ADDR_W    = 32;
    localparam logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    int                checks = 0;
    int                failures = 0;
    logic [31:0]       sb [$];
    logic [ADDR_W-1:0] exp_addr = BASE_ADDR;

    always #5 clk = ~clk;

    inst_encoder_loader_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    inst_encoder_loader #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );

    // Drain monitor: sampled on the falling edge, the drain itself happens on the next rising edge.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (!rst && !flush && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL drain_unexpected: got %h with empty scoreboard", bus.out_inst);
            end else begin
                exp = sb.pop_front();
                if (bus.out_inst !== exp) begin
                    failures++;
                    $display("[TB] FAIL out_inst: got %h expected %h", bus.out_inst, exp);
                end
                checks++;
                if (bus.out_addr !== exp_addr) begin
                    failures++;
                    $display("[TB] FAIL out_addr: got %h expected %h", bus.out_addr, exp_addr);
                end
                exp_addr = exp_addr + 4;
            end
        end
    end

    function automatic logic [31:0] model_encode(input logic [2:0] t, input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        case (t)
            3'd0:    return {f7, rs2, rs1, f3, rd, op};
            3'd1:    return {imm[11:0], rs1, f3, rd, op};
            3'd2:    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            3'd3:    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            3'd4:    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            3'd5:    return {imm[31:12], rd, op};
            default: return 32'h0000_0013;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] imm);
        bus.in_type   = t;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp);
        int n = 0;
        set_fields(t, op, rd, rs1, rs2, f3, f7, imm);
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready=%b expected 1", bus.in_ready);
        end else begin
            sb.push_back(exp);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_timeout: pending=%0d out_valid=%b expected 0/0",
                     sb.size(), bus.out_valid);
        end
    endtask

    task automatic do_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        exp_addr = BASE_ADDR;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (bus.count !== '0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++;
        if (bus.out_addr !== BASE_ADDR) begin failures++; $display("[TB] FAIL reset_out_addr: got %h expected %h", bus.out_addr, BASE_ADDR); end
        checks++;
        if (bus.err_illegal !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err_illegal); end
    endtask

    task automatic test_i_type;
        bus.out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093);
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL i_latency_valid: got %b expected 1", bus.out_valid); end
        checks++;
        if (bus.out_inst !== 32'h0050_0093) begin failures++; $display("[TB] FAIL i_latency_inst: got %h expected 00500093", bus.out_inst); end
        checks++;
        if (bus.count !== 3'd1) begin failures++; $display("[TB] FAIL i_count: got %0d expected 1", bus.count); end
        bus.out_ready = 1'b1;
        wait_empty();
        checks++;
        if (bus.out_addr !== BASE_ADDR + 32'd4) begin failures++; $display("[TB] FAIL i_addr_after: got %h expected %h", bus.out_addr, BASE_ADDR + 32'd4); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_r_s_sb;
        do_flush();
        bus.out_ready = 1'b1;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h0020_8463);
        wait_empty();
        checks++;
        if (bus.out_addr !== BASE_ADDR + 32'd12) begin failures++; $display("[TB] FAIL rssb_addr: got %h expected %h", bus.out_addr, BASE_ADDR + 32'd12); end
    endtask

    task automatic test_u_uj;
        bus.out_ready = 1'b1;
        send(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7);
        send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 32'h0100_00EF);
        wait_empty();
    endtask

    task automatic test_full;
        logic [31:0] first;
        logic [31:0] fifth;
        do_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e = model_encode(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 3 + 1));
            if (i == 0) first = e;
            send(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 3 + 1), e);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_in_ready: got %b expected 0", bus.in_ready); end
        checks++;
        if (bus.count !== 3'd4) begin failures++; $display("[TB] FAIL full_count: got %0d expected 4", bus.count); end
        fifth = model_encode(3'd0, 7'h33, 5'd9, 5'd7, 5'd8, 3'd4, 7'h20, 32'd0);
        set_fields(3'd0, 7'h33, 5'd9, 5'd7, 5'd8, 3'd4, 7'h20, 32'd0);
        bus.in_valid = 1'b1;
        tick();
        checks++;
        if (bus.count !== 3'd4) begin failures++; $display("[TB] FAIL full_held_count: got %0d expected 4", bus.count); end
        checks++;
        if (bus.out_inst !== first) begin failures++; $display("[TB] FAIL full_hold_inst: got %h expected %h", bus.out_inst, first); end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.count !== 3'd3 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_first_drain: count=%0d in_ready=%b expected 3/1", bus.count, bus.in_ready);
        end
        sb.push_back(fifth);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.count !== 3'd3) begin failures++; $display("[TB] FAIL full_accept_drain: got %0d expected 3", bus.count); end
        wait_empty();
    endtask

    task automatic test_illegal;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.err_illegal !== 1'b0) begin failures++; $display("[TB] FAIL illegal_pre: got %b expected 0", bus.err_illegal); end
        send(3'd7, 7'h33, 5'd4, 5'd5, 5'd6, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'h0000_0013);
        checks++;
        if (bus.err_illegal !== 1'b1) begin failures++; $display("[TB] FAIL illegal_pulse: got %b expected 1", bus.err_illegal); end
        tick();
        checks++;
        if (bus.err_illegal !== 1'b0) begin failures++; $display("[TB] FAIL illegal_width: got %b expected 0", bus.err_illegal); end
        send(3'd6, 7'h6F, 5'd2, 5'd3, 5'd4, 3'd5, 7'h11, 32'h0000_0ABC, 32'h0000_0013);
        wait_empty();
    endtask

    task automatic test_flush;
        bus.out_ready = 1'b1;
        send(3'd1, 7'h13, 5'd7, 5'd7, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0013_8393);
        wait_empty();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(3'd5, 7'h37, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, model_encode(3'd5, 7'h37, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000));
        checks++;
        if (bus.count !== 3'd3) begin failures++; $display("[TB] FAIL flush_pre_count: got %0d expected 3", bus.count); end
        set_fields(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        bus.in_valid = 1'b1;
        do_flush();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_state: count=%0d out_valid=%b in_ready=%b expected 0/0/1", bus.count, bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.out_addr !== BASE_ADDR) begin failures++; $display("[TB] FAIL flush_addr: got %h expected %h", bus.out_addr, BASE_ADDR); end
        checks++;
        if (bus.err_illegal !== 1'b1) begin failures++; $display("[TB] FAIL flush_err: got %b expected 1", bus.err_illegal); end
        bus.out_ready = 1'b1;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3);
        wait_empty();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(3'd1, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), model_encode(3'd1, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        exp_addr = BASE_ADDR;
        checks++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.out_addr !== BASE_ADDR) begin
            failures++;
            $display("[TB] FAIL rst_midstream: count=%0d out_valid=%b addr=%h expected 0/0/%h", bus.count, bus.out_valid, bus.out_addr, BASE_ADDR);
        end
    endtask

    task automatic test_back_to_back;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [2:0]  t   = 3'($urandom_range(0, 7));
                    logic [6:0]  op  = 7'($urandom);
                    logic [4:0]  rd  = 5'($urandom);
                    logic [4:0]  rs1 = 5'($urandom);
                    logic [4:0]  rs2 = 5'($urandom);
                    logic [2:0]  f3  = 3'($urandom);
                    logic [6:0]  f7  = 7'($urandom);
                    logic [31:0] imm = $urandom;
                    send(t, op, rd, rs1, rs2, f3, f7, imm, model_encode(t, op, rd, rs1, rs2, f3, f7, imm));
                end
            end
            begin
                repeat (60) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_empty();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        test_reset();
        test_i_type();
        test_r_s_sb();
        test_u_uj();
        test_full();
        test_illegal();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
